recolector: RTL and testbench



---
 rtl/recolector_pkg.sv | 17 +
 rtl/recolector_if.sv | 34 +++
 rtl/recolector_rr_sel.sv | 27 ++
 rtl/recolector.sv | 124 ++++++++++++
 tb/tb_recolector.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/recolector_pkg.sv
// Shared constants for the recolector drain-side FIFO reader: word layout,
// port count and FSM state encoding.
package recolector_pkg;

  localparam int DATA_W    = 10;
  localparam int CNT_W     = 8;
  localparam int DEST_LSB  = DATA_W - 2;
  localparam int NUM_PORTS = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

endpackage

// File: rtl/recolector_if.sv
// Bundle of the four output-FIFO read ports, the collected-word stream and
// the per-destination counters. master = recolector, slave = environment.
interface recolector_if;
  import recolector_pkg::*;

  word_t fifo_d0, fifo_d1, fifo_d2, fifo_d3;
  logic  fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3;
  logic  pop0, pop1, pop2, pop3;
  word_t dout;
  logic  dout_valid;
  logic  dout_ready;
  logic  [1:0] src;
  cnt_t  cnt0, cnt1, cnt2, cnt3;
  logic  err_dest;

  modport master (
    input  fifo_d0, fifo_d1, fifo_d2, fifo_d3,
    input  fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    input  dout_ready,
    output pop0, pop1, pop2, pop3,
    output dout, dout_valid, src,
    output cnt0, cnt1, cnt2, cnt3, err_dest
  );

  modport slave (
    output fifo_d0, fifo_d1, fifo_d2, fifo_d3,
    output fifo_empty0, fifo_empty1, fifo_empty2, fifo_empty3,
    output dout_ready,
    input  pop0, pop1, pop2, pop3,
    input  dout, dout_valid, src,
    input  cnt0, cnt1, cnt2, cnt3, err_dest
  );

endinterface

// File: rtl/recolector_rr_sel.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... mod 4.
module recolector_rr_sel
  import recolector_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [1:0]           ptr_i,
  output logic [1:0]           gnt_o,
  output logic                 any_o
);

  logic [1:0] idx;

  // Walk from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recolector.sv
// Round-robin drain of four output FIFOs onto one valid/ready stream with
// per-destination counters. Define DEST_CHECK_EN to build the destination check.
module recolector
  import recolector_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  recolector_if.master bus
);

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] src_q, src_d;
  word_t      dout_q, dout_d;
  logic       vld_q, vld_d;
  cnt_t       cnt_q [NUM_PORTS];
  cnt_t       cnt_d [NUM_PORTS];
  logic       err_q;

  word_t                fifo_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] req, pop;
  logic [1:0]           gnt;
  logic                 any;

  assign fifo_d[0] = bus.fifo_d0;
  assign fifo_d[1] = bus.fifo_d1;
  assign fifo_d[2] = bus.fifo_d2;
  assign fifo_d[3] = bus.fifo_d3;
  assign req = ~{bus.fifo_empty3, bus.fifo_empty2, bus.fifo_empty1, bus.fifo_empty0};

  recolector_rr_sel u_rr_sel (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .any_o (any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    dout_d   = dout_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    pop      = '0;
    case (state_q)
      IDLE: begin
        if (any) begin
          pop[gnt] = 1'b1;
          src_d    = gnt;
          state_d  = WAIT;
        end
      end
      // Registered FIFO read: the popped word is on fifo_d now.
      WAIT: begin
        dout_d   = fifo_d[src_q];
        vld_d    = 1'b1;
        rr_ptr_d = src_q + 2'd1;
        state_d  = SEND;
      end
      SEND: begin
        if (bus.dout_ready) begin
          vld_d         = 1'b0;
          cnt_d[src_q]  = sat_inc(cnt_q[src_q]);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      src_q    <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef DEST_CHECK_EN
  logic err_d;
  always_comb begin
    err_d = err_q;
    if (state_q == WAIT && fifo_d[src_q][DATA_W-1:DEST_LSB] != src_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign err_q = 1'b0;
`endif

  // Pops are combinational from IDLE; keep them quiet while reset is held.
  assign bus.pop0 = pop[0] & ~reset;
  assign bus.pop1 = pop[1] & ~reset;
  assign bus.pop2 = pop[2] & ~reset;
  assign bus.pop3 = pop[3] & ~reset;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.src        = src_q;
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];
  assign bus.cnt2       = cnt_q[2];
  assign bus.cnt3       = cnt_q[3];
  assign bus.err_dest   = err_q;

endmodule

// File: tb/tb_recolector.sv
// Self-checking bench for recolector: FIFO model, scoreboard of expected words
// and a reference count per destination.
module tb_recolector;
  import recolector_pkg::*;

  typedef struct {
    int    fifo;
    word_t word;
  } vec_t;

  typedef struct {
    word_t      data;
    logic [1:0] src;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  recolector_if bus ();

  recolector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  word_t fq [NUM_PORTS][$];
  exp_t  sb [$];
  int    exp_cnt [NUM_PORTS];
  logic  exp_err;
  logic [3:0] pop_s;
  vec_t  vecs [5];

  function automatic logic [3:0] pops();
    return {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
  endfunction

  function automatic int dut_cnt(input int n);
    case (n)
      0:       return int'(bus.cnt0);
      1:       return int'(bus.cnt1);
      2:       return int'(bus.cnt2);
      default: return int'(bus.cnt3);
    endcase
  endfunction

  task automatic set_port(input int n, input word_t d, input logic upd_d, input logic e);
    case (n)
      0: begin if (upd_d) bus.fifo_d0 = d; bus.fifo_empty0 = e; end
      1: begin if (upd_d) bus.fifo_d1 = d; bus.fifo_empty1 = e; end
      2: begin if (upd_d) bus.fifo_d2 = d; bus.fifo_empty2 = e; end
      default: begin if (upd_d) bus.fifo_d3 = d; bus.fifo_empty3 = e; end
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: score a handshake that the coming edge will take, advance the
  // FIFO model on the edge, and return at the following falling edge.
  task automatic cyc();
    exp_t e;
    if (!reset && bus.dout_valid && bus.dout_ready) begin
      chk("word_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout", int'(bus.dout), int'(e.data));
        chk("src", int'(bus.src), int'(e.src));
        if (exp_cnt[e.src] < 255) exp_cnt[e.src]++;
      end
    end
    pop_s = pops();
    chk("one_pop", int'($countones(pop_s) <= 1), 1);
    @(posedge clk);
    #1;
    for (int n = 0; n < NUM_PORTS; n++) begin
      if (pop_s[n] && fq[n].size() > 0) set_port(n, fq[n].pop_front(), 1'b1, 1'b0);
      set_port(n, '0, 1'b0, fq[n].size() == 0);
    end
    @(negedge clk);
  endtask

  task automatic load(input int n, input word_t w);
    fq[n].push_back(w);
  endtask

  task automatic expect_word(input word_t w, input int s);
    exp_t e;
    e.data = w;
    e.src  = 2'(s);
    sb.push_back(e);
  endtask

  task automatic chk_counts();
    for (int n = 0; n < NUM_PORTS; n++) chk($sformatf("cnt%0d", n), dut_cnt(n), exp_cnt[n]);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      cyc();
      k++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_pop(output logic found);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      if (pops() != 4'b0) found = 1'b1;
    end
  endtask

  initial begin
    logic found;

    vecs[0] = '{2, 10'h2AB};
    vecs[1] = '{0, 10'h011};
    vecs[2] = '{1, 10'h155};
    vecs[3] = '{2, 10'h200};
    vecs[4] = '{3, 10'h3C5};

    reset = 1'b1;
    bus.dout_ready = 1'b0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      set_port(n, '0, 1'b1, 1'b1);
      exp_cnt[n] = 0;
    end
    exp_err = 1'b0;
    @(negedge clk);
    repeat (3) cyc();

    chk("rst_pops", int'(pops()), 0);
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_src", int'(bus.src), 0);
    chk("rst_err", int'(bus.err_dest), 0);
    chk_counts();

    // Idle with all FIFOs empty and ready high.
    reset = 1'b0;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_pops", int'(pops()), 0);
      chk("idle_valid", int'(bus.dout_valid), 0);
    end
    chk_counts();

    // Single words: pop at n, word valid at n+2, counted after handshake.
    for (int i = 0; i < 5; i++) begin
      load(vecs[i].fifo, vecs[i].word);
      expect_word(vecs[i].word, vecs[i].fifo);
      wait_pop(found);
      chk("pop_seen", int'(found), 1);
      chk("pop_which", int'(pops()), 1 << vecs[i].fifo);
      cyc();
      chk("lat_n1_valid", int'(bus.dout_valid), 0);
      cyc();
      chk("lat_n2_valid", int'(bus.dout_valid), 1);
      chk("lat_n2_dout", int'(bus.dout), int'(vecs[i].word));
      chk("lat_n2_src", int'(bus.src), vecs[i].fifo);
      cyc();
      chk("post_valid", int'(bus.dout_valid), 0);
      chk_counts();
    end

    // All four FIFOs busy: grants rotate 0,1,2,3,0,1,2,3.
    load(0, 10'h011); load(0, 10'h0AA);
    load(1, 10'h122); load(1, 10'h1BB);
    load(2, 10'h233); load(2, 10'h2CC);
    load(3, 10'h344); load(3, 10'h3DD);
    expect_word(10'h011, 0); expect_word(10'h122, 1);
    expect_word(10'h233, 2); expect_word(10'h344, 3);
    expect_word(10'h0AA, 0); expect_word(10'h1BB, 1);
    expect_word(10'h2CC, 2); expect_word(10'h3DD, 3);
    wait_drain(60);
    chk_counts();
    chk("rr_err", int'(bus.err_dest), 0);

    // Backpressure stall with a second FIFO filling meanwhile.
    bus.dout_ready = 1'b0;
    load(0, 10'h0FF);
    expect_word(10'h0FF, 0);
    wait_pop(found);
    chk("stall_pop_seen", int'(found), 1);
    cyc();
    cyc();
    load(1, 10'h1EE);
    expect_word(10'h1EE, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", int'(bus.dout_valid), 1);
      chk("stall_dout", int'(bus.dout), 10'h0FF);
      chk("stall_pops", int'(pops()), 0);
      chk("stall_cnt0", dut_cnt(0), exp_cnt[0]);
    end
    bus.dout_ready = 1'b1;
    wait_drain(30);
    chk_counts();

    // Word whose destination field disagrees with its FIFO.
    load(1, 10'h3FF);
    expect_word(10'h3FF, 1);
    wait_drain(30);
`ifdef DEST_CHECK_EN
    exp_err = 1'b1;
`endif
    chk("err_after_bad", int'(bus.err_dest), int'(exp_err));
    load(2, 10'h2AB);
    expect_word(10'h2AB, 2);
    wait_drain(30);
    chk("err_sticky", int'(bus.err_dest), int'(exp_err));
    chk_counts();

    // Reset while a word is held in SEND.
    bus.dout_ready = 1'b0;
    load(2, 10'h222);
    for (int k = 0; k < 10 && !bus.dout_valid; k++) cyc();
    chk("pre_rst_valid", int'(bus.dout_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(bus.dout_valid), 0);
    chk("mid_rst_dout", int'(bus.dout), 0);
    chk("mid_rst_err", int'(bus.err_dest), 0);
    sb.delete();
    for (int n = 0; n < NUM_PORTS; n++) exp_cnt[n] = 0;
    exp_err = 1'b0;
    chk_counts();
    @(negedge clk);
    cyc();
    reset = 1'b0;
    bus.dout_ready = 1'b1;
    load(3, 10'h3AA);
    load(0, 10'h0BB);
    expect_word(10'h0BB, 0);
    expect_word(10'h3AA, 3);
    wait_drain(30);
    chk_counts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
